// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks the fetch PC, issues one imem read at a time, pushes words into the fetch queue.
// Optional JAL target prediction is enabled by defining FETCH_JAL_PREDICT_EN.

package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pred_pc;
  } fetch_queue_t;

endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [XLEN-1:0]    imem_addr,
  output logic               imem_read,
  input  logic               imem_resp,
  input  logic [XLEN-1:0]    imem_rdata,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               fq_push,
  output fetch_queue_t       fq_data,
  input  logic               fq_full
);

  localparam int unsigned OPC_W = 7;
  localparam logic [OPC_W-1:0] OPC_JAL = 7'b1101111;
  localparam logic [XLEN-1:0]  INSTR_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            read_q, read_d;
  logic            push_c;

  logic [XLEN-1:0] push_instr;
  logic [XLEN-1:0] pred_pc;
  logic [XLEN-1:0] redirect_tgt;
  logic            unused_redirect_lsb;

  // Redirect targets are forced to word alignment; the low bits are don't-care.
  assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // The instruction being offered to the queue: the held word in HOLD, the live response otherwise.
  assign push_instr = (state_q == ST_HOLD) ? hold_q : imem_rdata;

`ifdef FETCH_JAL_PREDICT_EN
  logic [XLEN-1:0] jal_imm;
  logic            is_jal;

  assign is_jal  = (push_instr[OPC_W-1:0] == OPC_JAL);
  assign jal_imm = {{11{push_instr[31]}}, push_instr[31], push_instr[19:12],
                    push_instr[20], push_instr[30:21], 1'b0};
  assign pred_pc = is_jal ? (addr_q + jal_imm) : (addr_q + INSTR_BYTES);
`else
  assign pred_pc = addr_q + INSTR_BYTES;
`endif

  // Next-state and push decode; redirect wins over everything in every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    read_d  = read_q;
    push_c  = 1'b0;

    unique case (state_q)
      ST_START: begin
        if (redirect) begin
          pc_d   = redirect_tgt;
          addr_d = redirect_tgt;
        end
        state_d = ST_REQ;
        read_d  = 1'b1;
      end

      ST_REQ: begin
        if (redirect) begin
          pc_d = redirect_tgt;
          if (imem_resp) begin
            addr_d = redirect_tgt;
          end else begin
            state_d = ST_DISCARD;
          end
        end else if (imem_resp) begin
          if (!fq_full) begin
            push_c = 1'b1;
            pc_d   = pred_pc;
            addr_d = pred_pc;
          end else begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
            read_d  = 1'b0;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          addr_d  = redirect_tgt;
          state_d = ST_REQ;
          read_d  = 1'b1;
        end else if (!fq_full) begin
          push_c  = 1'b1;
          pc_d    = pred_pc;
          addr_d  = pred_pc;
          state_d = ST_REQ;
          read_d  = 1'b1;
        end
      end

      ST_DISCARD: begin
        // A stale request is still in flight; its data is dropped when it returns.
        if (redirect) begin
          pc_d = redirect_tgt;
          if (imem_resp) begin
            addr_d  = redirect_tgt;
            state_d = ST_REQ;
          end
        end else if (imem_resp) begin
          addr_d  = pc_q;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_START;
        read_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_START;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      hold_q  <= '0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      read_q  <= read_d;
    end
  end

  assign imem_addr = addr_q;
  assign imem_read = read_q;

  // Push is a same-cycle strobe so a 1-cycle memory sustains one instruction per clock.
  assign fq_push = push_c & ~rst;
  assign fq_data = '{pc: addr_q, instr: push_instr, pred_pc: pred_pc};

endmodule
